// File: rtl/inst_sequencer.sv
// Instruction sequencer: FETCH/EXEC0/EXEC1 phase control, instruction latch and carry flag.
// Optional single-step gating of fetches is enabled by defining SEQ_STEP_EN.
module inst_sequencer #(
  parameter logic [7:0] RESET_INST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fetch_req,
  input  logic       fetch_valid,
  input  logic [7:0] fetch_data,
  input  logic       mem_wait,
  input  logic       WC,
  input  logic       alu_cout,
  input  logic       step,
  output logic [7:0] inst,
  output logic       cycle,
  output logic       ncycle,
  output logic       carry,
  output logic       retire,
  output logic [1:0] state
);

  // Handshake: a fetch completes on any cycle where fetch_req and fetch_valid
  // are both high; fetch_valid without fetch_req is ignored.
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC0 = 2'd1;
  localparam logic [1:0] S_EXEC1 = 2'd2;

  logic [1:0] state_nxt;
  logic       can_fetch;
  logic       fetch_done;
  logic       exec_exit;

`ifdef SEQ_STEP_EN
  logic step_pend;

  // One-deep step memory; a pulse in the completion cycle arms the next fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_pend <= 1'b0;
    end else if (step) begin
      step_pend <= 1'b1;
    end else if (fetch_done) begin
      step_pend <= 1'b0;
    end
  end

  assign can_fetch = step_pend;
`else
  logic unused_step;
  assign unused_step = step;
  assign can_fetch   = 1'b1;
`endif

  assign fetch_req  = (state == S_FETCH) & can_fetch & ~rst;
  assign fetch_done = fetch_req & fetch_valid;
  assign exec_exit  = ((state == S_EXEC0) | (state == S_EXEC1)) & ~mem_wait;
  assign retire     = (((state == S_EXEC0) & ~inst[7]) | (state == S_EXEC1))
                      & ~mem_wait & ~rst;
  assign ncycle     = ~cycle;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (fetch_done) state_nxt = S_EXEC0;
      S_EXEC0: begin
        if (!mem_wait) begin
          state_nxt = inst[7] ? S_EXEC1 : S_FETCH;
        end
      end
      S_EXEC1: if (!mem_wait) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      inst  <= RESET_INST;
      cycle <= 1'b0;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      cycle <= (state_nxt == S_EXEC1);
      if (fetch_done) begin
        inst <= fetch_data;
      end
      // Carry only moves on an unstalled exec exit, so it is stable into EXEC1.
      if (exec_exit && WC) begin
        carry <= alu_cout;
      end
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction transaction model.
module tb_inst_sequencer;

  logic       clk;
  logic       rst;
  logic       fetch_req;
  logic       fetch_valid;
  logic [7:0] fetch_data;
  logic       mem_wait;
  logic       WC;
  logic       alu_cout;
  logic       step;
  logic [7:0] inst;
  logic       cycle;
  logic       ncycle;
  logic       carry;
  logic       retire;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  // Model of architectural state: instruction being held and carry flag.
  logic [7:0] m_inst;
  logic       m_carry;

  inst_sequencer dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .mem_wait(mem_wait), .WC(WC), .alu_cout(alu_cout),
    .step(step), .inst(inst), .cycle(cycle), .ncycle(ncycle), .carry(carry),
    .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance.
  task automatic cyc(input logic fv, input logic [7:0] fd, input logic mw,
                     input logic wc, input logic co,
                     input logic e_req, input logic e_cyc, input logic e_ret,
                     input string tag);
    fetch_valid = fv; fetch_data = fd; mem_wait = mw; WC = wc; alu_cout = co;
    @(negedge clk);
    chk({tag, ".fetch_req"}, {7'd0, fetch_req}, {7'd0, e_req});
    chk({tag, ".inst"},      inst, m_inst);
    chk({tag, ".cycle"},     {7'd0, cycle}, {7'd0, e_cyc});
    chk({tag, ".ncycle"},    {7'd0, ncycle}, {7'd0, ~e_cyc});
    chk({tag, ".retire"},    {7'd0, retire}, {7'd0, e_ret});
    chk({tag, ".carry"},     {7'd0, carry}, {7'd0, m_carry});
    @(posedge clk);
    #1;
  endtask

  // One whole instruction: d idle fetch cycles, s0/s1 stall cycles per phase,
  // and the WC/alu_cout presented on each unstalled exec exit.
  task automatic run_inst(input logic [7:0] b, input int d, input int s0, input int s1,
                          input logic wc0, input logic co0,
                          input logic wc1, input logic co1, input string tag);
    for (int i = 0; i < d; i++)
      cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'b1, 1'b0, 1'b0, {tag, ".wait"});
    cyc(1'b1, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, {tag, ".fetch"});
    m_inst = b;
    for (int i = 0; i < s0; i++)
      cyc(1'($urandom), 8'($urandom), 1'b1, 1'($urandom), 1'($urandom),
          1'b0, 1'b0, 1'b0, {tag, ".stall0"});
    cyc(1'($urandom), 8'($urandom), 1'b0, wc0, co0, 1'b0, 1'b0, ~b[7], {tag, ".exec0"});
    if (wc0) m_carry = co0;
    if (b[7]) begin
      for (int i = 0; i < s1; i++)
        cyc(1'($urandom), 8'($urandom), 1'b1, 1'($urandom), 1'($urandom),
            1'b0, 1'b1, 1'b0, {tag, ".stall1"});
      cyc(1'($urandom), 8'($urandom), 1'b0, wc1, co1, 1'b0, 1'b1, 1'b1, {tag, ".exec1"});
      if (wc1) m_carry = co1;
    end
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_data = 8'h00; mem_wait = 1'b0;
    WC = 1'b0; alu_cout = 1'b0; step = 1'b0;
    m_inst = 8'h00; m_carry = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    fetch_valid = 1'b1; fetch_data = 8'h33; WC = 1'b1; alu_cout = 1'b1;
    @(negedge clk);
    chk("reset.fetch_req", {7'd0, fetch_req}, 8'd0);
    chk("reset.inst", inst, 8'h00);
    chk("reset.cycle", {7'd0, cycle}, 8'd0);
    chk("reset.ncycle", {7'd0, ncycle}, 8'd1);
    chk("reset.carry", {7'd0, carry}, 8'd0);
    chk("reset.retire", {7'd0, retire}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_inst(8'h41, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_41");
    run_inst(8'h90, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, "t2_90");
    run_inst(8'hE0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, "t3_E0");
    run_inst(8'h12, 5, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_idle");
    run_inst(8'h85, 1, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, "t5_stall");

    // Reset during EXEC1 of 8'hA5.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t6.fetch");
    m_inst = 8'hA5;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6.exec0");
    m_carry = 1'b1;
    rst = 1'b1; mem_wait = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_inst = 8'h00; m_carry = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t6.after_rst");

    for (int n = 0; n < 60; n++)
      run_inst(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
